// File: rtl/id_operand_stage_if.sv
// Handshake and write-back bundle between fetch, the operand stage, the ALU and write-back.
// The stage connects through the slave modport; the environment driving it uses master.
interface id_operand_stage_if #(
  parameter int DATA_W = 32
);
  logic              if_valid;
  logic [31:0]       if_instr;
  logic              if_ready;
  logic              ex_valid;
  logic              ex_ready;
  logic [31:0]       i_datain;
  logic [DATA_W-1:0] gr1;
  logic [DATA_W-1:0] gr2;
  logic              ex_wen;
  logic [4:0]        ex_dest;
  logic              wb_en;
  logic [4:0]        wb_addr;
  logic [DATA_W-1:0] wb_data;

  modport slave (
    input  if_valid, if_instr, ex_ready, wb_en, wb_addr, wb_data,
    output if_ready, ex_valid, i_datain, gr1, gr2, ex_wen, ex_dest
  );

  modport master (
    output if_valid, if_instr, ex_ready, wb_en, wb_addr, wb_data,
    input  if_ready, ex_valid, i_datain, gr1, gr2, ex_wen, ex_dest
  );
endinterface

// File: rtl/id_operand_stage.sv
// Decode/operand-fetch stage: register file, busy scoreboard, RAW stall and ALU-side output register.
// Optional macro ID_WB_BYPASS_EN forwards same-cycle write-back into operands and cancels the hazard.
module id_operand_stage #(
  parameter int DATA_W  = 32,
  parameter int REG_NUM = 32
) (
  input logic                clk,
  input logic                rst,
  id_operand_stage_if.slave  bus
);

  logic [DATA_W-1:0]  regs [REG_NUM];
  logic [REG_NUM-1:0] busy;

  logic [5:0] op;
  logic [5:0] fn;
  logic [4:0] rs;
  logic [4:0] rt;
  logic [4:0] rd;

  logic       has_dest;
  logic [4:0] dest;
  logic       use_rs;
  logic       use_rt;
  logic       rs_wb_hit;
  logic       rt_wb_hit;
  logic       haz;
  logic       issue;

  logic [DATA_W-1:0] rs_val;
  logic [DATA_W-1:0] rt_val;

  assign op = bus.if_instr[31:26];
  assign fn = bus.if_instr[5:0];
  assign rs = bus.if_instr[25:21];
  assign rt = bus.if_instr[20:16];
  assign rd = bus.if_instr[15:11];

  // Unrecognised opcodes fall through with no destination and no sources
  always_comb begin
    has_dest = 1'b0;
    dest     = 5'd0;
    use_rs   = 1'b0;
    use_rt   = 1'b0;
    case (op)
      6'b000000: begin
        has_dest = 1'b1;
        dest     = rd;
        use_rs   = !(fn == 6'b000000 || fn == 6'b000010 || fn == 6'b000011);
        use_rt   = 1'b1;
      end
      6'b001000, 6'b001001, 6'b001010, 6'b001011,
      6'b001100, 6'b001101, 6'b001110, 6'b100011: begin
        has_dest = 1'b1;
        dest     = rt;
        use_rs   = 1'b1;
      end
      6'b101011, 6'b000100, 6'b000101: begin
        use_rs = 1'b1;
        use_rt = 1'b1;
      end
      default: begin
        has_dest = 1'b0;
      end
    endcase
  end

`ifdef ID_WB_BYPASS_EN
  assign rs_wb_hit = bus.wb_en && (bus.wb_addr == rs);
  assign rt_wb_hit = bus.wb_en && (bus.wb_addr == rt);
`else
  assign rs_wb_hit = 1'b0;
  assign rt_wb_hit = 1'b0;
`endif

  assign rs_val = (rs == 5'd0) ? '0 : (rs_wb_hit ? bus.wb_data : regs[rs]);
  assign rt_val = (rt == 5'd0) ? '0 : (rt_wb_hit ? bus.wb_data : regs[rt]);

  assign haz = (use_rs && (rs != 5'd0) && busy[rs] && !rs_wb_hit) ||
               (use_rt && (rt != 5'd0) && busy[rt] && !rt_wb_hit);

  assign bus.if_ready = (!bus.ex_valid || bus.ex_ready) && !haz;
  assign issue        = bus.if_valid && bus.if_ready;

  // Write-back clear is scheduled before the issue set so a same-register set wins
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.ex_valid <= 1'b0;
      bus.ex_wen   <= 1'b0;
      bus.ex_dest  <= 5'd0;
      bus.i_datain <= 32'd0;
      bus.gr1      <= '0;
      bus.gr2      <= '0;
      busy         <= '0;
      for (int i = 0; i < REG_NUM; i++) begin
        regs[i] <= '0;
      end
    end else begin
      if (bus.wb_en && (bus.wb_addr != 5'd0)) begin
        regs[bus.wb_addr] <= bus.wb_data;
        busy[bus.wb_addr] <= 1'b0;
      end
      if (issue) begin
        bus.ex_valid <= 1'b1;
        bus.i_datain <= bus.if_instr;
        bus.gr1      <= rs_val;
        bus.gr2      <= rt_val;
        bus.ex_wen   <= has_dest;
        bus.ex_dest  <= dest;
        if (has_dest && (dest != 5'd0)) begin
          busy[dest] <= 1'b1;
        end
      end else if (bus.ex_ready) begin
        bus.ex_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_id_operand_stage.sv
// Directed bench for id_operand_stage: hazards, stalls, $0 handling, shift sources and reset.
// Expected values are hand-computed; bypass-dependent timing follows ID_WB_BYPASS_EN.
module tb_id_operand_stage;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  id_operand_stage_if #(.DATA_W(32)) bus ();

  id_operand_stage #(.DATA_W(32), .REG_NUM(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drives every fetch/ALU/write-back input at once
  task automatic applyStimulus(input logic v, input logic [31:0] instr, input logic rdy,
                               input logic we, input logic [4:0] wa, input logic [31:0] wd);
    bus.if_valid = v;
    bus.if_instr = instr;
    bus.ex_ready = rdy;
    bus.wb_en    = we;
    bus.wb_addr  = wa;
    bus.wb_data  = wd;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    applyStimulus(1'b0, 32'd0, 1'b0, 1'b0, 5'd0, 32'd0);
    tick();
    tick();
    rst = 1'b0;
    #1;
    checks++;
    if ({bus.ex_valid, bus.ex_wen, bus.ex_dest, bus.i_datain, bus.gr1, bus.gr2} !== 103'd0) begin
      failures++;
      $display("[TB] FAIL reset_outputs got v=%b w=%b d=%0d i=%h g1=%h g2=%h want all 0",
               bus.ex_valid, bus.ex_wen, bus.ex_dest, bus.i_datain, bus.gr1, bus.gr2);
    end
    checks++;
    if (bus.if_ready !== 1'b1) begin
      failures++;
      $display("[TB] FAIL reset_if_ready got %b want 1", bus.if_ready);
    end
  endtask

  task automatic preload(input logic [4:0] a, input logic [31:0] d);
    applyStimulus(1'b0, 32'd0, 1'b1, 1'b1, a, d);
    tick();
    applyStimulus(1'b0, 32'd0, 1'b1, 1'b0, 5'd0, 32'd0);
  endtask

  task automatic test_issue();
    applyStimulus(1'b1, 32'h00221821, 1'b1, 1'b0, 5'd0, 32'd0);
    #1;
    checks++;
    if (bus.if_ready !== 1'b1) begin
      failures++;
      $display("[TB] FAIL addu_if_ready got %b want 1", bus.if_ready);
    end
    tick();
    checks++;
    if ({bus.ex_valid, bus.ex_wen, bus.ex_dest, bus.i_datain, bus.gr1, bus.gr2} !==
        {1'b1, 1'b1, 5'd3, 32'h00221821, 32'd5, 32'd7}) begin
      failures++;
      $display("[TB] FAIL addu_issue got v=%b w=%b d=%0d i=%h g1=%0d g2=%0d want v=1 w=1 d=3 i=00221821 g1=5 g2=7",
               bus.ex_valid, bus.ex_wen, bus.ex_dest, bus.i_datain, bus.gr1, bus.gr2);
    end
  endtask

  task automatic test_hazard();
    applyStimulus(1'b1, 32'h20640001, 1'b1, 1'b0, 5'd0, 32'd0);
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if (bus.if_ready !== 1'b0) begin
        failures++;
        $display("[TB] FAIL raw_stall cycle %0d got if_ready=%b want 0", i, bus.if_ready);
      end
      tick();
    end
    checks++;
    if (bus.ex_valid !== 1'b0) begin
      failures++;
      $display("[TB] FAIL raw_bubble got ex_valid=%b want 0", bus.ex_valid);
    end
    applyStimulus(1'b1, 32'h20640001, 1'b1, 1'b1, 5'd3, 32'd12);
    #1;
    checks++;
`ifdef ID_WB_BYPASS_EN
    if (bus.if_ready !== 1'b1) begin
      failures++;
      $display("[TB] FAIL wb_cancel got if_ready=%b want 1", bus.if_ready);
    end
    tick();
    applyStimulus(1'b0, 32'd0, 1'b1, 1'b0, 5'd0, 32'd0);
`else
    if (bus.if_ready !== 1'b0) begin
      failures++;
      $display("[TB] FAIL wb_extra_stall got if_ready=%b want 0", bus.if_ready);
    end
    tick();
    applyStimulus(1'b1, 32'h20640001, 1'b1, 1'b0, 5'd0, 32'd0);
    #1;
    checks++;
    if (bus.if_ready !== 1'b1) begin
      failures++;
      $display("[TB] FAIL wb_after_stall got if_ready=%b want 1", bus.if_ready);
    end
    tick();
    applyStimulus(1'b0, 32'd0, 1'b1, 1'b0, 5'd0, 32'd0);
`endif
    checks++;
    if ({bus.ex_valid, bus.ex_wen, bus.ex_dest, bus.i_datain, bus.gr1} !==
        {1'b1, 1'b1, 5'd4, 32'h20640001, 32'd12}) begin
      failures++;
      $display("[TB] FAIL addi_issue got v=%b w=%b d=%0d i=%h g1=%0d want v=1 w=1 d=4 i=20640001 g1=12",
               bus.ex_valid, bus.ex_wen, bus.ex_dest, bus.i_datain, bus.gr1);
    end
  endtask

  task automatic test_stall();
    applyStimulus(1'b1, 32'hAC220000, 1'b0, 1'b0, 5'd0, 32'd0);
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if (bus.if_ready !== 1'b0) begin
        failures++;
        $display("[TB] FAIL backpressure_ready cycle %0d got %b want 0", i, bus.if_ready);
      end
      tick();
      checks++;
      if ({bus.ex_valid, bus.ex_wen, bus.ex_dest, bus.i_datain, bus.gr1, bus.gr2} !==
          {1'b1, 1'b1, 5'd4, 32'h20640001, 32'd12, 32'd0}) begin
        failures++;
        $display("[TB] FAIL backpressure_hold cycle %0d got v=%b w=%b d=%0d i=%h g1=%0d g2=%0d want v=1 w=1 d=4 i=20640001 g1=12 g2=0",
                 i, bus.ex_valid, bus.ex_wen, bus.ex_dest, bus.i_datain, bus.gr1, bus.gr2);
      end
    end
    bus.ex_ready = 1'b1;
    #1;
    checks++;
    if (bus.if_ready !== 1'b1) begin
      failures++;
      $display("[TB] FAIL sw_ready got %b want 1", bus.if_ready);
    end
    tick();
    checks++;
    if ({bus.ex_valid, bus.ex_wen, bus.ex_dest, bus.i_datain, bus.gr1, bus.gr2} !==
        {1'b1, 1'b0, 5'd0, 32'hAC220000, 32'd5, 32'd7}) begin
      failures++;
      $display("[TB] FAIL sw_issue got v=%b w=%b d=%0d i=%h g1=%0d g2=%0d want v=1 w=0 d=0 i=ac220000 g1=5 g2=7",
               bus.ex_valid, bus.ex_wen, bus.ex_dest, bus.i_datain, bus.gr1, bus.gr2);
    end
  endtask

  task automatic test_reg0();
    preload(5'd0, 32'h0000FFFF);
    applyStimulus(1'b1, 32'h00002825, 1'b1, 1'b0, 5'd0, 32'd0);
    tick();
    checks++;
    if ({bus.ex_valid, bus.ex_dest, bus.gr1, bus.gr2} !== {1'b1, 5'd5, 32'd0, 32'd0}) begin
      failures++;
      $display("[TB] FAIL reg0_read got v=%b d=%0d g1=%h g2=%h want v=1 d=5 g1=0 g2=0",
               bus.ex_valid, bus.ex_dest, bus.gr1, bus.gr2);
    end
    applyStimulus(1'b1, 32'h00220021, 1'b1, 1'b0, 5'd0, 32'd0);
    tick();
    applyStimulus(1'b1, 32'h20090001, 1'b1, 1'b0, 5'd0, 32'd0);
    #1;
    checks++;
    if (bus.if_ready !== 1'b1) begin
      failures++;
      $display("[TB] FAIL reg0_never_busy got if_ready=%b want 1", bus.if_ready);
    end
    tick();
    checks++;
    if ({bus.ex_valid, bus.ex_dest, bus.gr1} !== {1'b1, 5'd9, 32'd0}) begin
      failures++;
      $display("[TB] FAIL reg0_addi got v=%b d=%0d g1=%h want v=1 d=9 g1=0",
               bus.ex_valid, bus.ex_dest, bus.gr1);
    end
  endtask

  task automatic test_shift_sources();
    preload(5'd7, 32'h00000077);
    applyStimulus(1'b1, 32'h00420821, 1'b1, 1'b0, 5'd0, 32'd0);
    tick();
    applyStimulus(1'b1, 32'h00200021, 1'b1, 1'b0, 5'd0, 32'd0);
    #1;
    checks++;
    if (bus.if_ready !== 1'b0) begin
      failures++;
      $display("[TB] FAIL busy1_stall got if_ready=%b want 0", bus.if_ready);
    end
    applyStimulus(1'b1, 32'h00273080, 1'b1, 1'b0, 5'd0, 32'd0);
    #1;
    checks++;
    if (bus.if_ready !== 1'b1) begin
      failures++;
      $display("[TB] FAIL sll_rs_ignored got if_ready=%b want 1", bus.if_ready);
    end
    applyStimulus(1'b1, 32'h00073080, 1'b1, 1'b0, 5'd0, 32'd0);
    #1;
    checks++;
    if (bus.if_ready !== 1'b1) begin
      failures++;
      $display("[TB] FAIL sll_ready got if_ready=%b want 1", bus.if_ready);
    end
    tick();
    checks++;
    if ({bus.ex_valid, bus.ex_wen, bus.ex_dest, bus.gr2} !== {1'b1, 1'b1, 5'd6, 32'h77}) begin
      failures++;
      $display("[TB] FAIL sll_issue got v=%b w=%b d=%0d g2=%h want v=1 w=1 d=6 g2=77",
               bus.ex_valid, bus.ex_wen, bus.ex_dest, bus.gr2);
    end
  endtask

  task automatic test_reset_inflight();
    applyStimulus(1'b1, 32'h00001825, 1'b1, 1'b0, 5'd0, 32'd0);
    tick();
    rst = 1'b1;
    applyStimulus(1'b0, 32'd0, 1'b0, 1'b1, 5'd7, 32'h55);
    tick();
    rst = 1'b0;
    applyStimulus(1'b1, 32'h20640001, 1'b1, 1'b0, 5'd0, 32'd0);
    #1;
    checks++;
    if ({bus.ex_valid, bus.ex_wen, bus.ex_dest, bus.i_datain, bus.gr1, bus.gr2} !== 103'd0) begin
      failures++;
      $display("[TB] FAIL inflight_reset got v=%b w=%b d=%0d i=%h g1=%h g2=%h want all 0",
               bus.ex_valid, bus.ex_wen, bus.ex_dest, bus.i_datain, bus.gr1, bus.gr2);
    end
    checks++;
    if (bus.if_ready !== 1'b1) begin
      failures++;
      $display("[TB] FAIL post_reset_ready got %b want 1", bus.if_ready);
    end
    tick();
    checks++;
    if ({bus.ex_valid, bus.ex_dest, bus.gr1} !== {1'b1, 5'd4, 32'd0}) begin
      failures++;
      $display("[TB] FAIL post_reset_addi got v=%b d=%0d g1=%h want v=1 d=4 g1=0",
               bus.ex_valid, bus.ex_dest, bus.gr1);
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst      = 1'b1;
    applyStimulus(1'b0, 32'd0, 1'b0, 1'b0, 5'd0, 32'd0);
    #2;
    test_reset();
    preload(5'd1, 32'd5);
    preload(5'd2, 32'd7);
    test_issue();
    test_hazard();
    test_stall();
    test_reg0();
    test_shift_sources();
    test_reset_inflight();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
